// File: rtl/v850_exec_pkg.sv
// rtl/v850_exec_pkg.sv - shared encodings, state type and latency helpers for the V850 issue sequencer
//
// Contents:
//   CS_MUL, CS_DIV   executer circuit-select encodings of the multi-cycle units
//   seq_state_t      sequencer state (IDLE / EXEC)
//   sel_latency()    issue-to-retire latency for a circuit select
//   cnt_width()      width of the latency down-counter (never below 6 bits)
package v850_exec_pkg;

   localparam logic [9:0] CS_MUL = 10'b00_1000_0000;
   localparam logic [9:0] CS_DIV = 10'b00_0000_1000;

   localparam int unsigned CNT_MIN_W = 6;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } seq_state_t;

   // Every circuit other than MUL and DIV completes in a single cycle.
   function automatic int unsigned sel_latency(input logic [9:0] sel,
                                               input int unsigned mul_lat,
                                               input int unsigned div_lat);
      int unsigned lat;
      lat = 1;
      if (sel == CS_MUL) begin
         lat = mul_lat;
      end else if (sel == CS_DIV) begin
         lat = div_lat;
      end
      return lat;
   endfunction

   // Wide enough to hold the larger latency, so longer dividers need no edits.
   function automatic int unsigned cnt_width(input int unsigned mul_lat,
                                             input int unsigned div_lat);
      int unsigned max_lat;
      int unsigned w;
      max_lat = (mul_lat > div_lat) ? mul_lat : div_lat;
      w = $clog2(max_lat + 1);
      return (w < CNT_MIN_W) ? CNT_MIN_W : w;
   endfunction

endpackage

// File: rtl/v850_exec_sequencer_if.sv
// rtl/v850_exec_sequencer_if.sv - decoder/executer bus of the V850 issue sequencer
//
// Signals:
//   flush_i                          kill in-flight op and pending state
//   dec_valid_i / dec_ready_o        decoder handshake
//   dec_circuit_sel_i [9:0]          executer circuit select
//   dec_dest_i, dec_dest2_i [4:0]    destination registers
//   dec_wr_dest_i, dec_wr_dest2_i    destination write enables
//   dec_src1_i, dec_src2_i [4:0]     source registers
//   ex_valid_o                       one-cycle issue strobe
//   ex_circuit_sel_o [9:0]           issued circuit select (0 when not issuing)
//   ex_dest_o, ex_dest2_o [4:0]      issued destinations
//   ex_done_o                        one-cycle retirement pulse
//   busy_o                           an op is in flight
//   pending_o [31:0]                 outstanding register writes
// Modports: master = decoder/executer side, slave = sequencer.
interface v850_exec_sequencer_if;

   logic        flush_i;
   logic        dec_valid_i;
   logic        dec_ready_o;
   logic [9:0]  dec_circuit_sel_i;
   logic [4:0]  dec_dest_i;
   logic [4:0]  dec_dest2_i;
   logic        dec_wr_dest_i;
   logic        dec_wr_dest2_i;
   logic [4:0]  dec_src1_i;
   logic [4:0]  dec_src2_i;
   logic        ex_valid_o;
   logic [9:0]  ex_circuit_sel_o;
   logic [4:0]  ex_dest_o;
   logic [4:0]  ex_dest2_o;
   logic        ex_done_o;
   logic        busy_o;
   logic [31:0] pending_o;

   modport master (
      output flush_i, dec_valid_i, dec_circuit_sel_i, dec_dest_i, dec_dest2_i,
             dec_wr_dest_i, dec_wr_dest2_i, dec_src1_i, dec_src2_i,
      input  dec_ready_o, ex_valid_o, ex_circuit_sel_o, ex_dest_o, ex_dest2_o,
             ex_done_o, busy_o, pending_o
   );

   modport slave (
      input  flush_i, dec_valid_i, dec_circuit_sel_i, dec_dest_i, dec_dest2_i,
             dec_wr_dest_i, dec_wr_dest2_i, dec_src1_i, dec_src2_i,
      output dec_ready_o, ex_valid_o, ex_circuit_sel_o, ex_dest_o, ex_dest2_o,
             ex_done_o, busy_o, pending_o
   );

endinterface

// File: rtl/v850_scoreboard.sv
// rtl/v850_scoreboard.sv - 32-entry pending-write scoreboard for the V850 issue sequencer
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   clear_all                        synchronous clear of every pending bit
//   set0_en/set0_idx, set1_en/idx    mark registers pending
//   clr0_en/clr0_idx, clr1_en/idx    release registers
//   look_idx0..3                     registers to look up
//   look_hit [3:0]                   registered pending state of each lookup
//   pending [31:0]                   full pending vector
module v850_scoreboard (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_all,
   input  logic        set0_en,
   input  logic [4:0]  set0_idx,
   input  logic        set1_en,
   input  logic [4:0]  set1_idx,
   input  logic        clr0_en,
   input  logic [4:0]  clr0_idx,
   input  logic        clr1_en,
   input  logic [4:0]  clr1_idx,
   input  logic [4:0]  look_idx0,
   input  logic [4:0]  look_idx1,
   input  logic [4:0]  look_idx2,
   input  logic [4:0]  look_idx3,
   output logic [3:0]  look_hit,
   output logic [31:0] pending
);

   logic [31:0] pend_q;
   logic [31:0] set_mask;
   logic [31:0] clr_mask;

   function automatic logic [31:0] onehot(input logic en, input logic [4:0] idx);
      return {31'b0, en} << idx;
   endfunction

   assign set_mask = onehot(set0_en, set0_idx) | onehot(set1_en, set1_idx);
   assign clr_mask = onehot(clr0_en, clr0_idx) | onehot(clr1_en, clr1_idx);

   // Set is applied after clear so a register handed straight from the
   // retiring op to the new op stays pending; r0 is hard-wired clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else if (clear_all) begin
         pend_q <= '0;
      end else begin
         pend_q <= ((pend_q & ~clr_mask) | set_mask) & ~32'h1;
      end
   end

   assign look_hit[0] = pend_q[look_idx0];
   assign look_hit[1] = pend_q[look_idx1];
   assign look_hit[2] = pend_q[look_idx2];
   assign look_hit[3] = pend_q[look_idx3];
   assign pending     = pend_q;

endmodule

// File: rtl/v850_exec_sequencer.sv
// rtl/v850_exec_sequencer.sv - issue controller between the V850 decoder and execute stage
//
// Parameters:
//   MUL_LATENCY   issue-to-retire cycles for MUL (>= 1)
//   DIV_LATENCY   issue-to-retire cycles for DIV (>= 1)
// Ports:
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   bus           v850_exec_sequencer_if.slave: decoder handshake, issue strobe,
//                 retirement pulse, busy flag and pending-write vector
// Build option:
//   V850_SEQ_SCOREBOARD_EN  when defined, a register scoreboard stalls RAW/WAW
//                           hazards and drives pending_o; otherwise ordering
//                           relies only on multi-cycle blocking and pending_o = 0.
module v850_exec_sequencer
   import v850_exec_pkg::*;
#(
   parameter int unsigned MUL_LATENCY = 2,
   parameter int unsigned DIV_LATENCY = 34
) (
   input  logic                  clk,
   input  logic                  rst_n,
   v850_exec_sequencer_if.slave  bus
);

   localparam int unsigned CNT_W = cnt_width(MUL_LATENCY, DIV_LATENCY);

   seq_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] lat;
   logic             ex_valid_q;
   logic             ex_done_q;
   logic [9:0]       ex_sel_q;
   logic [4:0]       ex_dest_q;
   logic [4:0]       ex_dest2_q;
   logic             retire;
   logic             hazard;
   logic             ready;
   logic             accept;
   logic [31:0]      pending;

   // The last cycle of an op doubles as an issue slot for the next one.
   assign retire = (state == ST_EXEC) && (cnt == CNT_W'(1));
   assign ready  = ((state == ST_IDLE) || retire) && !hazard && !bus.flush_i;
   assign accept = bus.dec_valid_i && ready;
   assign lat    = CNT_W'(sel_latency(bus.dec_circuit_sel_i, MUL_LATENCY, DIV_LATENCY));

   // ex_done_q is computed one cycle ahead so it is high exactly while cnt == 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         ex_valid_q <= 1'b0;
         ex_done_q  <= 1'b0;
         ex_sel_q   <= '0;
         ex_dest_q  <= '0;
         ex_dest2_q <= '0;
      end else if (bus.flush_i) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         ex_valid_q <= 1'b0;
         ex_done_q  <= 1'b0;
         ex_sel_q   <= '0;
      end else begin
         ex_valid_q <= accept;
         ex_sel_q   <= accept ? bus.dec_circuit_sel_i : 10'b0;
         if (accept) begin
            state      <= ST_EXEC;
            cnt        <= lat;
            ex_dest_q  <= bus.dec_dest_i;
            ex_dest2_q <= bus.dec_dest2_i;
            ex_done_q  <= (lat == CNT_W'(1));
         end else if (state == ST_EXEC) begin
            if (retire) begin
               state     <= ST_IDLE;
               cnt       <= '0;
               ex_done_q <= 1'b0;
            end else begin
               cnt       <= cnt - CNT_W'(1);
               ex_done_q <= (cnt == CNT_W'(2));
            end
         end else begin
            ex_done_q <= 1'b0;
         end
      end
   end

`ifdef V850_SEQ_SCOREBOARD_EN
   logic       ex_wr_q;
   logic       ex_wr2_q;
   logic [3:0] hits;

   // Write enables of the in-flight op, needed to release its bits on retire.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_wr_q  <= 1'b0;
         ex_wr2_q <= 1'b0;
      end else if (accept) begin
         ex_wr_q  <= bus.dec_wr_dest_i;
         ex_wr2_q <= bus.dec_wr_dest2_i;
      end
   end

   v850_scoreboard u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_all (bus.flush_i),
      .set0_en   (accept && bus.dec_wr_dest_i),
      .set0_idx  (bus.dec_dest_i),
      .set1_en   (accept && bus.dec_wr_dest2_i),
      .set1_idx  (bus.dec_dest2_i),
      .clr0_en   (retire && ex_wr_q),
      .clr0_idx  (ex_dest_q),
      .clr1_en   (retire && ex_wr2_q),
      .clr1_idx  (ex_dest2_q),
      .look_idx0 (bus.dec_src1_i),
      .look_idx1 (bus.dec_src2_i),
      .look_idx2 (bus.dec_dest_i),
      .look_idx3 (bus.dec_dest2_i),
      .look_hit  (hits),
      .pending   (pending)
   );

   // Uses the registered vector: a bit being released this cycle still stalls.
   assign hazard = hits[0] || hits[1]
                || (hits[2] && bus.dec_wr_dest_i)
                || (hits[3] && bus.dec_wr_dest2_i);
`else
   logic unused_sb_inputs;

   assign hazard           = 1'b0;
   assign pending          = '0;
   assign unused_sb_inputs = ^{bus.dec_src1_i, bus.dec_src2_i,
                               bus.dec_wr_dest_i, bus.dec_wr_dest2_i};
`endif

   assign bus.dec_ready_o      = ready;
   assign bus.ex_valid_o       = ex_valid_q;
   assign bus.ex_circuit_sel_o = ex_sel_q;
   assign bus.ex_dest_o        = ex_dest_q;
   assign bus.ex_dest2_o       = ex_dest2_q;
   assign bus.ex_done_o        = ex_done_q;
   assign bus.busy_o           = (state == ST_EXEC);
   assign bus.pending_o        = pending;

endmodule

// File: tb/tb_v850_exec_sequencer.sv
// tb/tb_v850_exec_sequencer.sv - scoreboard bench for v850_exec_sequencer (directed + random ops)
`timescale 1ns/1ps
module tb_v850_exec_sequencer;

   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 34;
`ifdef V850_SEQ_SCOREBOARD_EN
   localparam bit SB_EN = 1'b1;
`else
   localparam bit SB_EN = 1'b0;
`endif
   localparam logic [9:0] SEL_ADD = 10'b00_0010_0001;
   localparam logic [9:0] SEL_AND = 10'b00_0100_0000;
   localparam logic [9:0] SEL_MUL = 10'b00_1000_0000;
   localparam logic [9:0] SEL_DIV = 10'b00_0000_1000;

   typedef struct packed {
      logic [9:0] sel;
      logic [4:0] d;
      logic [4:0] d2;
      logic       w;
      logic       w2;
      logic [4:0] s1;
      logic [4:0] s2;
   } op_t;

   typedef struct packed {
      int         cyc;
      logic [9:0] sel;
      logic [4:0] d;
      logic [4:0] d2;
   } issue_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   issue_t issue_q[$];
   int     done_q[$];

   // Reference model: at most one op is ever in flight, so the expected
   // pending set is exactly the in-flight op's written destinations.
   bit  m_busy = 1'b0;
   int  m_issue_cyc = 0;
   int  m_ret_cyc = 0;
   op_t m_op = '0;

   v850_exec_sequencer_if bus ();

   v850_exec_sequencer #(
      .MUL_LATENCY (MUL_LAT),
      .DIV_LATENCY (DIV_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int lat_of(input logic [9:0] sel);
      if (sel == SEL_MUL) return MUL_LAT;
      if (sel == SEL_DIV) return DIV_LAT;
      return 1;
   endfunction

   function automatic logic [31:0] dest_mask(input op_t o);
      logic [31:0] m;
      m = '0;
      if (o.w)  m[o.d]  = 1'b1;
      if (o.w2) m[o.d2] = 1'b1;
      m[0] = 1'b0;
      return SB_EN ? m : 32'h0;
   endfunction

   function automatic op_t mk(input logic [9:0] sel, input logic [4:0] d, input bit w,
                              input logic [4:0] d2, input bit w2,
                              input logic [4:0] s1, input logic [4:0] s2);
      op_t o;
      o.sel = sel; o.d = d; o.w = w; o.d2 = d2; o.w2 = w2; o.s1 = s1; o.s2 = s2;
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      int  k;
      k = $urandom_range(0, 31);
      if (k == 0)      o.sel = SEL_DIV;
      else if (k < 6)  o.sel = SEL_MUL;
      else if (k < 16) o.sel = SEL_ADD;
      else             o.sel = 10'($urandom);
      o.d  = 5'($urandom_range(0, 7));
      o.d2 = 5'($urandom_range(0, 7));
      o.s1 = 5'($urandom_range(0, 7));
      o.s2 = 5'($urandom_range(0, 7));
      o.w  = 1'($urandom_range(0, 1));
      o.w2 = 1'($urandom_range(0, 3) == 0);
      return o;
   endfunction

   // One clock cycle: drive inputs (called #1 after a rising edge), check the
   // cycle-level outputs at the falling edge, then advance the model.
   task automatic do_cycle(input bit v, input op_t o, input bit fl, output bit acc);
      logic [31:0] pend;
      bit          retire;
      bit          haz;
      bit          exp_ready;
      int          c;
      issue_t      ie;
      bus.dec_valid_i       = v;
      bus.dec_circuit_sel_i = o.sel;
      bus.dec_dest_i        = o.d;
      bus.dec_dest2_i       = o.d2;
      bus.dec_wr_dest_i     = o.w;
      bus.dec_wr_dest2_i    = o.w2;
      bus.dec_src1_i        = o.s1;
      bus.dec_src2_i        = o.s2;
      bus.flush_i           = fl;
      @(negedge clk);
      c         = cyc;
      retire    = m_busy && (c == m_ret_cyc);
      pend      = m_busy ? dest_mask(m_op) : 32'h0;
      haz       = pend[o.s1] | pend[o.s2] | (o.w & pend[o.d]) | (o.w2 & pend[o.d2]);
      exp_ready = (!m_busy || retire) && !haz && !fl;
      chk("dec_ready", 32'(bus.dec_ready_o), 32'(exp_ready));
      chk("busy", 32'(bus.busy_o), 32'(m_busy));
      chk("pending", bus.pending_o, pend);
      acc = v && exp_ready;
      if (fl) begin
         m_busy = 1'b0;
         done_q.delete();
      end else if (acc) begin
         m_busy      = 1'b1;
         m_op        = o;
         m_issue_cyc = c + 1;
         m_ret_cyc   = c + lat_of(o.sel);
         ie.cyc = c + 1; ie.sel = o.sel; ie.d = o.d; ie.d2 = o.d2;
         issue_q.push_back(ie);
         done_q.push_back(m_ret_cyc);
      end else if (retire) begin
         m_busy = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input op_t o);
      bit acc;
      acc = 1'b0;
      for (int i = 0; i < 64 && !acc; i++) do_cycle(1'b1, o, 1'b0, acc);
      chk("accept_bound", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) do_cycle(1'b0, '0, 1'b0, a);
   endtask

   // Monitor: pops the expected issue/retire records when the DUT presents them.
   initial begin
      issue_t ie;
      bit     exp_v;
      bit     exp_d;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            exp_v = (issue_q.size() != 0) && (issue_q[0].cyc == cyc);
            chk("ex_valid", 32'(bus.ex_valid_o), 32'(exp_v));
            if (exp_v) begin
               ie = issue_q.pop_front();
               chk("ex_circuit_sel", 32'(bus.ex_circuit_sel_o), 32'(ie.sel));
               chk("ex_dest", 32'(bus.ex_dest_o), 32'(ie.d));
               chk("ex_dest2", 32'(bus.ex_dest2_o), 32'(ie.d2));
            end else begin
               chk("ex_sel_idle", 32'(bus.ex_circuit_sel_o), 32'd0);
            end
            exp_d = (done_q.size() != 0) && (done_q[0] == cyc);
            chk("ex_done", 32'(bus.ex_done_o), 32'(exp_d));
            if (exp_d) void'(done_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a;
      bus.flush_i = 1'b0; bus.dec_valid_i = 1'b0; bus.dec_circuit_sel_i = '0;
      bus.dec_dest_i = '0; bus.dec_dest2_i = '0; bus.dec_wr_dest_i = 1'b0;
      bus.dec_wr_dest2_i = 1'b0; bus.dec_src1_i = '0; bus.dec_src2_i = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex_valid", 32'(bus.ex_valid_o), 32'd0);
      chk("rst_ex_done", 32'(bus.ex_done_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_pending", bus.pending_o, 32'd0);
      chk("rst_ex_sel", 32'(bus.ex_circuit_sel_o), 32'd0);
      chk("rst_ex_dest", 32'(bus.ex_dest_o), 32'd0);
      chk("rst_ex_dest2", 32'(bus.ex_dest2_o), 32'd0);
      chk("rst_dec_ready", 32'(bus.dec_ready_o), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Independent back-to-back ADDs.
      send(mk(SEL_ADD, 5'd3, 1, 5'd0, 0, 5'd1, 5'd2));
      send(mk(SEL_ADD, 5'd4, 1, 5'd0, 0, 5'd1, 5'd2));
      idle(3);
      // RAW on r5.
      send(mk(SEL_ADD, 5'd5, 1, 5'd0, 0, 5'd1, 5'd2));
      send(mk(SEL_AND, 5'd8, 1, 5'd0, 0, 5'd5, 5'd1));
      idle(2);
      // MUL writing r6/r7, then a reader of r6.
      send(mk(SEL_MUL, 5'd6, 1, 5'd7, 1, 5'd1, 5'd2));
      send(mk(SEL_ADD, 5'd9, 1, 5'd0, 0, 5'd6, 5'd2));
      idle(3);
      // DIV then a dependent op.
      send(mk(SEL_DIV, 5'd10, 1, 5'd0, 0, 5'd1, 5'd2));
      send(mk(SEL_ADD, 5'd11, 1, 5'd0, 0, 5'd10, 5'd2));
      idle(2);
      // Flush in cycle 10 of a DIV, with an op offered in the flush cycle.
      send(mk(SEL_DIV, 5'd12, 1, 5'd13, 1, 5'd1, 5'd2));
      idle(9);
      do_cycle(1'b1, mk(SEL_ADD, 5'd14, 1, 5'd0, 0, 5'd12, 5'd13), 1'b1, a);
      chk("flush_no_accept", 32'(a), 32'd0);
      send(mk(SEL_ADD, 5'd14, 1, 5'd0, 0, 5'd12, 5'd13));
      idle(2);
      // r0 never pending.
      send(mk(SEL_ADD, 5'd0, 1, 5'd0, 1, 5'd1, 5'd2));
      send(mk(SEL_ADD, 5'd2, 1, 5'd0, 0, 5'd0, 5'd0));
      idle(2);
      // Reset in the middle of a DIV.
      send(mk(SEL_DIV, 5'd15, 1, 5'd0, 0, 5'd1, 5'd2));
      idle(5);
      rst_n = 1'b0;
      m_busy = 1'b0;
      issue_q.delete();
      done_q.delete();
      #2;
      chk("midrst_busy", 32'(bus.busy_o), 32'd0);
      chk("midrst_pending", bus.pending_o, 32'd0);
      chk("midrst_ex_done", 32'(bus.ex_done_o), 32'd0);
      chk("midrst_dec_ready", 32'(bus.dec_ready_o), 32'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle(2);

      // Randomized traffic with occasional flushes in quiet cycles.
      for (int n = 0; n < 300; n++) begin
         int gap;
         bit fl;
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            fl = ($urandom_range(0, 15) == 0)
              && !(m_busy && (cyc == m_issue_cyc || cyc == m_ret_cyc));
            do_cycle(1'b0, '0, fl, a);
         end
         send(rand_op());
      end
      idle(DIV_LAT + 4);
      chk("issue_q_drained", 32'(issue_q.size()), 32'd0);
      chk("done_q_drained", 32'(done_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
